// File: rtl/pc_pkg.sv
// pc_pkg: next-PC mode encodings shared by the PC sequencer and its bench.
// No ports; provides PC_MODE_W and the PC_* mode constants.
package pc_pkg;
   localparam int PC_MODE_W = 3;
   localparam logic [PC_MODE_W-1:0] PC_SEQ  = 3'd0;
   localparam logic [PC_MODE_W-1:0] PC_BREL = 3'd1;
   localparam logic [PC_MODE_W-1:0] PC_JABS = 3'd2;
   localparam logic [PC_MODE_W-1:0] PC_JREG = 3'd3;
   localparam logic [PC_MODE_W-1:0] PC_CALL = 3'd4;
   localparam logic [PC_MODE_W-1:0] PC_RET  = 3'd5;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with saturating level and sticky flags.
// Ports: clk, rst (sync, active-low), push/pop requests, push_data in,
// top_data (entry[wp-1]) out, level (valid entries) out, ovf/unf sticky out.
module pc_ras
   import pc_pkg::*;
#(
   parameter int PC_W      = 10,
   parameter int RAS_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [PC_W-1:0]            push_data,
   output logic [PC_W-1:0]            top_data,
   output logic [$clog2(RAS_DEPTH):0] level,
   output logic                       ovf,
   output logic                       unf
);
   localparam int AW = $clog2(RAS_DEPTH);
   localparam int LW = AW + 1;
   logic [PC_W-1:0] mem_q [RAS_DEPTH];
   logic [AW-1:0]   wp_q, wp_d, wp_m1;
   logic [LW-1:0]   level_q, level_d;
   logic            ovf_q, ovf_d, unf_q, unf_d;
   logic            full, empty, do_pop;
   assign wp_m1    = wp_q - AW'(1);
   assign full     = level_q == LW'(RAS_DEPTH);
   assign empty    = level_q == '0;
   assign do_pop   = pop && !empty;
   assign top_data = mem_q[wp_m1];
   assign level    = level_q;
   assign ovf      = ovf_q;
   assign unf      = unf_q;
   // Pushing into a full stack wraps wp onto the oldest entry, so level saturates.
   always_comb begin
      wp_d    = push ? wp_q + AW'(1) : do_pop ? wp_m1 : wp_q;
      level_d = (push && !full) ? level_q + LW'(1) : do_pop ? level_q - LW'(1) : level_q;
      ovf_d   = ovf_q | (push && full);
      unf_d   = unf_q | (pop && empty);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         wp_q    <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end
   // Contents need no reset: level=0 already marks every entry invalid.
   always_ff @(posedge clk) begin
      if (rst && push) mem_q[wp_q] <= push_data;
   end
endmodule

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: instruction-fetch program counter with branch, jump, call/return.
// Ports: clk, rst (sync, active-low), stall (freeze), mode (next-PC select),
// offset (signed branch offset), target (jump/call/register address),
// count (fetch address), ras_level, ras_ovf, ras_unf (stack status).
module pc_seq_unit
   import pc_pkg::*;
#(
   parameter int PC_W      = 10,
   parameter int OFF_W     = 10,
   parameter int RAS_DEPTH = 4,
   parameter int RESET_PC  = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic [PC_MODE_W-1:0]       mode,
   input  logic [OFF_W-1:0]           offset,
   input  logic [PC_W-1:0]            target,
   output logic [PC_W-1:0]            count,
   output logic [$clog2(RAS_DEPTH):0] ras_level,
   output logic                       ras_ovf,
   output logic                       ras_unf
);
   logic [PC_W-1:0] count_q, count_d, seq_pc, boff, ras_top;
   logic            push, pop, take_jump;
   assign seq_pc    = count_q + PC_W'(1);
   assign boff      = PC_W'($signed(offset));
   assign take_jump = mode == PC_JABS || mode == PC_JREG || mode == PC_CALL;
   assign push      = !stall && mode == PC_CALL;
   assign pop       = !stall && mode == PC_RET;
   // Reserved modes and a return on an empty stack fall through to sequential.
   always_comb begin
      count_d = stall                                ? count_q :
                mode == PC_BREL                      ? count_q + boff :
                take_jump                            ? target :
                (mode == PC_RET && ras_level != '0)  ? ras_top :
                                                       seq_pc;
   end
   always_ff @(posedge clk) begin
      if (!rst) count_q <= PC_W'(RESET_PC);
      else      count_q <= count_d;
   end
   assign count = count_q;
   pc_ras #(
      .PC_W     (PC_W),
      .RAS_DEPTH(RAS_DEPTH)
   ) u_ras (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .push_data(seq_pc),
      .top_data (ras_top),
      .level    (ras_level),
      .ovf      (ras_ovf),
      .unf      (ras_unf)
   );
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed vectors with a queue-based scoreboard for pc_seq_unit.
module tb_pc_seq_unit;
   import pc_pkg::*;
   typedef struct packed {
      logic [9:0] c;
      logic [2:0] l;
      logic       o;
      logic       u;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       stall = 1'b0;
   logic [2:0] mode = PC_SEQ;
   logic [9:0] offset = '0;
   logic [9:0] target = '0;
   logic [9:0] count;
   logic [2:0] ras_level;
   logic       ras_ovf, ras_unf;
   exp_t       q[$];
   exp_t       e;
   int         n_vec = 0;
   int         n_bad = 0;
   always #5 clk = ~clk;
   pc_seq_unit #(
      .PC_W(10), .OFF_W(10), .RAS_DEPTH(4), .RESET_PC(0)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .mode(mode), .offset(offset),
      .target(target), .count(count), .ras_level(ras_level),
      .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );
   task automatic step(input logic r, input logic s, input logic [2:0] m,
                       input logic [9:0] o, input logic [9:0] t, input logic [9:0] ec,
                       input logic [2:0] el, input logic eo, input logic eu);
      @(negedge clk);
      rst = r; stall = s; mode = m; offset = o; target = t;
      q.push_back('{c: ec, l: el, o: eo, u: eu});
   endtask
   always @(posedge clk) begin
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         n_vec++;
         if ({count, ras_level, ras_ovf, ras_unf} !== e) begin
            n_bad++;
            $display("FAIL vec%0d: got count=%0d level=%0d ovf=%b unf=%b, want count=%0d level=%0d ovf=%b unf=%b",
                     n_vec, count, ras_level, ras_ovf, ras_unf, e.c, e.l, e.o, e.u);
         end
      end
   end
   initial begin
      step(0, 0, PC_CALL, 0, 55, 0, 0, 0, 0);
      step(0, 0, PC_CALL, 0, 55, 0, 0, 0, 0);
      step(1, 0, PC_SEQ,  0, 0, 1, 0, 0, 0);
      step(1, 0, PC_SEQ,  0, 0, 2, 0, 0, 0);
      step(1, 0, PC_SEQ,  0, 0, 3, 0, 0, 0);
      step(1, 0, PC_JABS, 0, 1023, 1023, 0, 0, 0);
      step(1, 0, PC_SEQ,  0, 0, 0, 0, 0, 0);
      step(1, 0, PC_JREG, 0, 5, 5, 0, 0, 0);
      step(1, 0, PC_BREL, 10'h3FE, 0, 3, 0, 0, 0);
      step(1, 0, PC_JABS, 0, 1020, 1020, 0, 0, 0);
      step(1, 0, PC_BREL, 8, 0, 4, 0, 0, 0);
      step(1, 0, PC_JABS, 0, 16, 16, 0, 0, 0);
      step(1, 0, PC_CALL, 0, 100, 100, 1, 0, 0);
      step(1, 0, PC_CALL, 0, 200, 200, 2, 0, 0);
      step(1, 0, PC_RET,  0, 0, 101, 1, 0, 0);
      step(1, 0, PC_RET,  0, 0, 17, 0, 0, 0);
      step(1, 0, PC_JABS, 0, 10, 10, 0, 0, 0);
      step(1, 0, PC_CALL, 0, 20, 20, 1, 0, 0);
      step(1, 0, PC_CALL, 0, 30, 30, 2, 0, 0);
      step(1, 0, PC_CALL, 0, 40, 40, 3, 0, 0);
      step(1, 0, PC_CALL, 0, 50, 50, 4, 0, 0);
      step(1, 0, PC_CALL, 0, 60, 60, 4, 1, 0);
      step(1, 0, PC_RET,  0, 0, 51, 3, 1, 0);
      step(1, 0, PC_RET,  0, 0, 41, 2, 1, 0);
      step(1, 0, PC_RET,  0, 0, 31, 1, 1, 0);
      step(1, 0, PC_RET,  0, 0, 21, 0, 1, 0);
      step(1, 0, PC_JABS, 0, 7, 7, 0, 1, 0);
      step(1, 0, PC_RET,  0, 0, 8, 0, 1, 1);
      step(1, 0, PC_SEQ,  0, 0, 9, 0, 1, 1);
      step(1, 0, 3'd6,    0, 300, 10, 0, 1, 1);
      step(1, 0, 3'd7,    0, 300, 11, 0, 1, 1);
      step(1, 0, PC_JABS, 0, 29, 29, 0, 1, 1);
      step(1, 0, PC_CALL, 0, 40, 40, 1, 1, 1);
      step(1, 1, PC_RET,  0, 0, 40, 1, 1, 1);
      step(1, 1, PC_RET,  0, 0, 40, 1, 1, 1);
      step(1, 1, PC_JABS, 0, 99, 40, 1, 1, 1);
      step(1, 0, PC_RET,  0, 0, 30, 0, 1, 1);
      step(1, 0, PC_JABS, 0, 5, 5, 0, 1, 1);
      step(1, 0, PC_CALL, 0, 9, 9, 1, 1, 1);
      step(0, 1, PC_RET,  0, 0, 0, 0, 0, 0);
      step(1, 0, PC_RET,  0, 0, 1, 0, 0, 1);
      step(1, 0, PC_SEQ,  0, 0, 2, 0, 0, 1);
      repeat (4) @(posedge clk);
      #2;
      n_vec++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d vectors left unchecked, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
